// File: rtl/shared_adder_arbiter.sv
// Round-robin controller sharing one N-bit adder between two valid/ready requesters.
// Optional per-requester grant counters are enabled by defining SHARE_STATS_EN.
module shared_adder_arbiter #(
  parameter int N     = 4,
  parameter int CNT_W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         IN_reqValid0,
  input  logic [N-1:0] IN_opA0,
  input  logic [N-1:0] IN_opB0,
  output logic         OUT_reqReady0,
  input  logic         IN_reqValid1,
  input  logic [N-1:0] IN_opA1,
  input  logic [N-1:0] IN_opB1,
  output logic         OUT_reqReady1,
  output logic         OUT_resValid0,
  output logic [N-1:0] OUT_res0,
  input  logic         IN_resReady0,
  output logic         OUT_resValid1,
  output logic [N:0]   OUT_res1,
  input  logic         IN_resReady1,
  output logic         OUT_lastGrant
`ifdef SHARE_STATS_EN
  ,
  output logic [CNT_W-1:0] OUT_grantCnt0,
  output logic [CNT_W-1:0] OUT_grantCnt1
`endif
);

  typedef enum logic {
    PRI0 = 1'b0,
    PRI1 = 1'b1
  } pri_e;

  pri_e         pri_q, pri_d;
  logic         res_valid0_q, res_valid0_d;
  logic         res_valid1_q, res_valid1_d;
  logic [N-1:0] res0_q, res0_d;
  logic [N:0]   res1_q, res1_d;
  logic         last_grant_q, last_grant_d;

  logic         elig0_s, elig1_s;
  logic         grant0_s, grant1_s;
  logic [N-1:0] op_a_s, op_b_s;
  logic [N:0]   sum_s;

  // A slot that drains this cycle may be refilled in the same cycle.
  always_comb begin
    elig0_s  = IN_reqValid0 & (~res_valid0_q | IN_resReady0);
    elig1_s  = IN_reqValid1 & (~res_valid1_q | IN_resReady1);
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if (rst) begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end else if (elig0_s && elig1_s) begin
      grant0_s = (pri_q == PRI0);
      grant1_s = (pri_q == PRI1);
    end else begin
      grant0_s = elig0_s;
      grant1_s = elig1_s;
    end
  end

  assign OUT_reqReady0 = grant0_s;
  assign OUT_reqReady1 = grant1_s;

  // The single shared adder; operands come from the granted requester only.
  always_comb begin
    if (grant1_s) begin
      op_a_s = IN_opA1;
      op_b_s = IN_opB1;
    end else begin
      op_a_s = IN_opA0;
      op_b_s = IN_opB0;
    end
    sum_s = {1'b0, op_a_s} + {1'b0, op_b_s};
  end

  // Next-state for priority, last grant and both result slots.
  always_comb begin
    pri_d        = pri_q;
    last_grant_d = last_grant_q;
    res_valid0_d = res_valid0_q;
    res_valid1_d = res_valid1_q;
    res0_d       = res0_q;
    res1_d       = res1_q;

    if (grant0_s) begin
      pri_d        = PRI1;
      last_grant_d = 1'b0;
    end else if (grant1_s) begin
      pri_d        = PRI0;
      last_grant_d = 1'b1;
    end else begin
      pri_d        = pri_q;
      last_grant_d = last_grant_q;
    end

    if (grant0_s) begin
      res0_d       = sum_s[N-1:0];
      res_valid0_d = 1'b1;
    end else if (res_valid0_q && IN_resReady0) begin
      res_valid0_d = 1'b0;
    end else begin
      res_valid0_d = res_valid0_q;
    end

    if (grant1_s) begin
      res1_d       = sum_s;
      res_valid1_d = 1'b1;
    end else if (res_valid1_q && IN_resReady1) begin
      res_valid1_d = 1'b0;
    end else begin
      res_valid1_d = res_valid1_q;
    end
  end

  // State registers; reset drops any in-flight result.
  always_ff @(posedge clk) begin
    if (rst) begin
      pri_q        <= PRI0;
      last_grant_q <= 1'b0;
      res_valid0_q <= 1'b0;
      res_valid1_q <= 1'b0;
      res0_q       <= {N{1'b0}};
      res1_q       <= {(N+1){1'b0}};
    end else begin
      pri_q        <= pri_d;
      last_grant_q <= last_grant_d;
      res_valid0_q <= res_valid0_d;
      res_valid1_q <= res_valid1_d;
      res0_q       <= res0_d;
      res1_q       <= res1_d;
    end
  end

  assign OUT_resValid0 = res_valid0_q;
  assign OUT_resValid1 = res_valid1_q;
  assign OUT_res0      = res0_q;
  assign OUT_res1      = res1_q;
  assign OUT_lastGrant = last_grant_q;

`ifdef SHARE_STATS_EN
  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;

  // Saturating grant counters.
  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (grant0_s && (cnt0_q != {CNT_W{1'b1}})) begin
      cnt0_d = cnt0_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt0_d = cnt0_q;
    end
    if (grant1_s && (cnt1_q != {CNT_W{1'b1}})) begin
      cnt1_d = cnt1_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt1_d = cnt1_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt0_q <= {CNT_W{1'b0}};
      cnt1_q <= {CNT_W{1'b0}};
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign OUT_grantCnt0 = cnt0_q;
  assign OUT_grantCnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_shared_adder_arbiter.sv
// Randomized + directed bench for shared_adder_arbiter (N=4) against a behavioural model.
module tb_shared_adder_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       v0, v1, rr0, rr1;
  logic [3:0] a0, b0, a1, b1;
  logic       OUT_reqReady0, OUT_reqReady1, OUT_resValid0, OUT_resValid1, OUT_lastGrant;
  logic [3:0] OUT_res0;
  logic [4:0] OUT_res1;
`ifdef SHARE_STATS_EN
  logic [7:0] OUT_grantCnt0, OUT_grantCnt1;
`endif

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model: preferred requester index, result slots, last grant, counters.
  int m_pref, m_last, m_r0, m_r1, m_cnt0, m_cnt1;
  bit m_v0, m_v1;

  always #5 clk = ~clk;

  shared_adder_arbiter #(.N(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .IN_reqValid0(v0), .IN_opA0(a0), .IN_opB0(b0), .OUT_reqReady0(OUT_reqReady0),
    .IN_reqValid1(v1), .IN_opA1(a1), .IN_opB1(b1), .OUT_reqReady1(OUT_reqReady1),
    .OUT_resValid0(OUT_resValid0), .OUT_res0(OUT_res0), .IN_resReady0(rr0),
    .OUT_resValid1(OUT_resValid1), .OUT_res1(OUT_res1), .IN_resReady1(rr1),
    .OUT_lastGrant(OUT_lastGrant)
`ifdef SHARE_STATS_EN
    , .OUT_grantCnt0(OUT_grantCnt0), .OUT_grantCnt1(OUT_grantCnt1)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic drive(input bit iv0, input int ia0, input int ib0, input bit iv1,
                       input int ia1, input int ib1, input bit irr0, input bit irr1);
    v0 = iv0; a0 = 4'(ia0); b0 = 4'(ib0);
    v1 = iv1; a1 = 4'(ia1); b1 = 4'(ib1);
    rr0 = irr0; rr1 = irr1;
  endtask

  // One cycle: check ready against model, clock, update model, check registered outputs.
  task automatic step();
    bit e0, e1, g0, g1;
    #1;
    e0 = v0 && (!m_v0 || rr0);
    e1 = v1 && (!m_v1 || rr1);
    if (rst) begin
      g0 = 1'b0; g1 = 1'b0;
    end else if (e0 && e1) begin
      g0 = (m_pref == 0); g1 = (m_pref == 1);
    end else begin
      g0 = e0; g1 = e1;
    end
    check_eq("reqReady0", 32'(OUT_reqReady0), 32'(g0));
    check_eq("reqReady1", 32'(OUT_reqReady1), 32'(g1));
    check_eq("oneReady", 32'(OUT_reqReady0 & OUT_reqReady1), 32'd0);
    @(posedge clk);
    if (rst) begin
      m_pref = 0; m_last = 0; m_v0 = 0; m_v1 = 0; m_r0 = 0; m_r1 = 0; m_cnt0 = 0; m_cnt1 = 0;
    end else begin
      if (g0) begin
        m_r0 = (int'(a0) + int'(b0)) % 16; m_v0 = 1; m_pref = 1; m_last = 0;
        if (m_cnt0 < 255) m_cnt0++;
      end else if (m_v0 && rr0) m_v0 = 0;
      if (g1) begin
        m_r1 = int'(a1) + int'(b1); m_v1 = 1; m_pref = 0; m_last = 1;
        if (m_cnt1 < 255) m_cnt1++;
      end else if (m_v1 && rr1) m_v1 = 0;
    end
    #1;
    check_eq("resValid0", 32'(OUT_resValid0), 32'(m_v0));
    check_eq("resValid1", 32'(OUT_resValid1), 32'(m_v1));
    check_eq("res0", 32'(OUT_res0), 32'(m_r0));
    check_eq("res1", 32'(OUT_res1), 32'(m_r1));
    check_eq("lastGrant", 32'(OUT_lastGrant), 32'(m_last));
`ifdef SHARE_STATS_EN
    check_eq("grantCnt0", 32'(OUT_grantCnt0), 32'(m_cnt0));
    check_eq("grantCnt1", 32'(OUT_grantCnt1), 32'(m_cnt1));
`endif
    @(negedge clk);
  endtask

  initial begin
    m_pref = 0; m_last = 0; m_v0 = 0; m_v1 = 0; m_r0 = 0; m_r1 = 0; m_cnt0 = 0; m_cnt1 = 0;
    rst = 1'b1;
    drive(1, 3, 4, 1, 5, 6, 1, 1);
    @(negedge clk);

    // Reset with both requesters valid: no ready, outputs zero.
    step();
    step();
    rst = 1'b0;

    // Only req0, 9+9 wraps to 2.
    drive(1, 9, 9, 0, 0, 0, 1, 1);
    step();
    check_eq("wrap_res0", 32'(OUT_res0), 32'd2);
    check_eq("wrap_valid0", 32'(OUT_resValid0), 32'd1);
    check_eq("wrap_last", 32'(OUT_lastGrant), 32'd0);

    // Only req1, 15+15 keeps carry.
    drive(0, 0, 0, 1, 15, 15, 1, 1);
    step();
    check_eq("carry_res1", 32'(OUT_res1), 32'd30);
    check_eq("carry_valid1", 32'(OUT_resValid1), 32'd1);

    // Both valid from PRI0 after reset: alternate 0,1,0,1.
    rst = 1'b1; drive(0, 0, 0, 0, 0, 0, 1, 1); step(); rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive(1, k, 2, 1, k, 7, 1, 1);
      #1;
      check_eq("alt_ready0", 32'(OUT_reqReady0), 32'((k % 2) == 0));
      step();
    end

    // Stalled slot 0: req1 takes every cycle, res0 holds, drain re-enables req0 at once.
    drive(1, 6, 5, 0, 0, 0, 0, 1);
    step();
    for (int k = 0; k < 4; k++) begin
      drive(1, 1, 1, 1, k, 3, 0, 1);
      #1;
      check_eq("stall_ready1", 32'(OUT_reqReady1), 32'd1);
      step();
      check_eq("stall_res0", 32'(OUT_res0), 32'd11);
    end
    drive(1, 2, 2, 1, 1, 1, 1, 1);
    #1;
    check_eq("drain_ready0", 32'(OUT_reqReady0), 32'd1);
    step();

    // Reset the cycle after a grant drops the pending result.
    drive(1, 4, 4, 0, 0, 0, 0, 0);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("rst_drop_valid0", 32'(OUT_resValid0), 32'd0);
    drive(1, 1, 1, 1, 1, 1, 1, 1);
    #1;
    check_eq("rst_pri0", 32'(OUT_reqReady0), 32'd1);
    step();

`ifdef SHARE_STATS_EN
    rst = 1'b1; step(); rst = 1'b0;
    for (int k = 0; k < 300; k++) begin
      drive(1, k % 16, 1, 0, 0, 0, 1, 1);
      step();
    end
    check_eq("sat_cnt0", 32'(OUT_grantCnt0), 32'd255);
`endif

    // Randomized traffic with occasional reset.
    for (int k = 0; k < 500; k++) begin
      rst = ($urandom_range(0, 39) == 0);
      drive(bit'($urandom_range(0, 3) != 0), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
            bit'($urandom_range(0, 3) != 0), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
            bit'($urandom_range(0, 2) != 0), bit'($urandom_range(0, 2) != 0));
      step();
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
